// File: rtl/ram_port_arbiter.sv
// Arbitrates the unified single-port RAM between instruction fetch (I) and
// load/store (D); every access is IDLE -> ACCESS -> RESP with registered outputs.
//
// Ports:
//   CLK, Rst                 clock, synchronous active-high reset
//   i_req/i_addr             I-port read request, held until i_ack
//   i_ack/i_rdata            I-port one-cycle completion pulse, read data register
//   d_req/d_we/d_addr/d_wdata  D-port request (1=write), held until d_ack
//   d_ack/d_rdata            D-port one-cycle completion pulse, read data register
//   ram_addr/ram_data        RAM address and bidirectional data bus
//   ram_rw/ram_cs            RAM write strobe (1=write) and chip select
//   busy                     high whenever the FSM is not in IDLE
module ram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_rw,
    output logic              ram_cs,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              owner_d;
    logic              last_d;
    logic [DATA_W-1:0] wdata_q;

    logic              gnt_i, gnt_d;
    logic              cs_nxt, rw_nxt;
    logic              i_ack_nxt, d_ack_nxt;
    logic              cap_i, cap_d;
    logic              owner_nxt, last_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              busy_nxt;

    // Round-robin tie break: I wins a tie only if D was granted last.
    assign gnt_i = i_req & (~d_req | last_d);
    assign gnt_d = d_req & ~gnt_i;

    // ram_rw is high only for an ACCESS-write, so the bus is never
    // driven while the RAM itself may be driving it.
    assign ram_data = ram_rw ? wdata_q : {DATA_W{1'bz}};

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            last_d   <= 1'b1;
            wdata_q  <= '0;
            ram_addr <= '0;
            ram_cs   <= 1'b0;
            ram_rw   <= 1'b0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner_d  <= owner_nxt;
            last_d   <= last_nxt;
            wdata_q  <= wdata_nxt;
            ram_addr <= addr_nxt;
            ram_cs   <= cs_nxt;
            ram_rw   <= rw_nxt;
            i_ack    <= i_ack_nxt;
            d_ack    <= d_ack_nxt;
            busy     <= busy_nxt;
            if (cap_i) i_rdata <= ram_data;
            if (cap_d) d_rdata <= ram_data;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (i_req | d_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Computes the values the registered outputs take after this edge.
    always_comb begin
        cs_nxt    = 1'b0;
        rw_nxt    = 1'b0;
        i_ack_nxt = 1'b0;
        d_ack_nxt = 1'b0;
        cap_i     = 1'b0;
        cap_d     = 1'b0;
        owner_nxt = owner_d;
        last_nxt  = last_d;
        addr_nxt  = ram_addr;
        wdata_nxt = wdata_q;
        unique case (state)
            IDLE: begin
                if (gnt_i | gnt_d) begin
                    cs_nxt    = 1'b1;
                    owner_nxt = gnt_d;
                    last_nxt  = gnt_d;
                    addr_nxt  = gnt_d ? d_addr : i_addr;
                    rw_nxt    = gnt_d & d_we;
                    wdata_nxt = d_wdata;
                end
            end
            ACCESS: begin
                i_ack_nxt = ~owner_d;
                d_ack_nxt = owner_d;
                cap_i     = ~owner_d & ~ram_rw;
                cap_d     = owner_d & ~ram_rw;
            end
            default: ;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule
